// File: rtl/ir_encoder.sv
// Pulse-distance IR frame transmitter: leader, MSB-first data bits, stop mark, trailing gap.
// Also emits the short repeat frame. Drives a level output plus a carrier-modulated LED output.
module ir_encoder #(
  parameter int unsigned CODEBITS     = 32,
  parameter int unsigned CLK_PER_TICK = 1000,
  parameter int unsigned CARRIER_HALF = 1316
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODEBITS-1:0] code,
  input  logic                send,
  input  logic                send_repeat,
  output logic                busy,
  output logic                done,
  output logic                tx,
  output logic                tx_mod
);

  localparam int unsigned CntW = $clog2(900 * CLK_PER_TICK + 1);
  localparam int unsigned BitW = $clog2(CODEBITS + 1);
  localparam int unsigned CarW = $clog2(CARRIER_HALF + 1);

  localparam int unsigned TLeadMark   = 900;
  localparam int unsigned TLeadSpace  = 450;
  localparam int unsigned TRptSpace   = 225;
  localparam int unsigned TBitMark    = 56;
  localparam int unsigned TZeroSpace  = 56;
  localparam int unsigned TOneSpace   = 169;
  localparam int unsigned TStopMark   = 56;
  localparam int unsigned TGap        = 300;

  // done is registered, so it is raised on the edge entering the final gap cycle
  localparam logic [CntW-1:0] GapPenult = CntW'(TGap * CLK_PER_TICK - 2);
  localparam logic [BitW-1:0] LastBit   = BitW'(CODEBITS - 1);
  localparam logic [CarW-1:0] CarLast   = CarW'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } state_e;

  state_e              st_q, st_d;
  logic [CntW-1:0]     cnt_q;
  logic [BitW-1:0]     bitcnt_q;
  logic [CODEBITS-1:0] sreg_q;
  logic [CarW-1:0]     car_q;
  logic                rpt_q;
  logic                busy_q, done_q, tx_q, tx_mod_q;

  int unsigned         phase_ticks;
  logic [CntW-1:0]     phase_len;
  logic                last;
  logic                adv;
  logic                mark_d;

  always_comb begin
    phase_ticks = 1;
    unique case (st_q)
      StLeadMark:  phase_ticks = TLeadMark;
      StLeadSpace: phase_ticks = rpt_q ? TRptSpace : TLeadSpace;
      StBitMark:   phase_ticks = TBitMark;
      StBitSpace:  phase_ticks = sreg_q[CODEBITS-1] ? TOneSpace : TZeroSpace;
      StStopMark:  phase_ticks = TStopMark;
      StGap:       phase_ticks = TGap;
      default:     phase_ticks = 1;
    endcase
    phase_len = CntW'(phase_ticks * CLK_PER_TICK);
    last      = (cnt_q == phase_len - CntW'(1));
  end

  always_comb begin
    st_d = st_q;
    adv  = (st_q != StIdle) && last;
    unique case (st_q)
      StIdle: begin
        if (send || send_repeat) begin
          st_d = StLeadMark;
          adv  = 1'b1;
        end
      end
      StLeadMark:  if (last) st_d = StLeadSpace;
      StLeadSpace: if (last) st_d = rpt_q ? StStopMark : StBitMark;
      StBitMark:   if (last) st_d = StBitSpace;
      StBitSpace:  if (last) st_d = (bitcnt_q == LastBit) ? StStopMark : StBitMark;
      StStopMark:  if (last) st_d = StGap;
      StGap:       if (last) st_d = StIdle;
      default:     st_d = StIdle;
    endcase
    mark_d = (st_d == StLeadMark) || (st_d == StBitMark) || (st_d == StStopMark);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      car_q    <= '0;
      rpt_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
      tx_mod_q <= 1'b0;
    end else begin
      st_q <= st_d;
      // Phase timer restarts on every state entry
      if (adv || st_q == StIdle) cnt_q <= '0;
      else                       cnt_q <= cnt_q + CntW'(1);

      if (st_q == StIdle) begin
        if (send) begin
          sreg_q <= code;
          rpt_q  <= 1'b0;
        end else if (send_repeat) begin
          rpt_q  <= 1'b1;
        end
      end
      if (st_q == StLeadSpace && adv) bitcnt_q <= '0;
      if (st_q == StBitSpace && adv) begin
        sreg_q   <= sreg_q << 1;
        bitcnt_q <= bitcnt_q + BitW'(1);
      end

      busy_q <= (st_d != StIdle);
      done_q <= (st_q == StGap) && (cnt_q == GapPenult);
      tx_q   <= ~mark_d;

      // Carrier phase is aligned to mark entry, starting high
      if (mark_d && adv) begin
        car_q    <= '0;
        tx_mod_q <= 1'b1;
      end else if (mark_d) begin
        if (car_q == CarLast) begin
          car_q    <= '0;
          tx_mod_q <= ~tx_mod_q;
        end else begin
          car_q <= car_q + CarW'(1);
        end
      end else begin
        car_q    <= '0;
        tx_mod_q <= 1'b0;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign tx     = tx_q;
  assign tx_mod = tx_mod_q;

endmodule

// File: doc/ir_encoder.md
# ir_encoder

Transmit-side counterpart of the IR decoder: serialises a `CODEBITS`-wide command into a pulse-distance IR frame (leader, data bits MSB first, stop mark, trailing gap). It also emits the short repeat frame. It drives a level output `tx` whose waveform matches what the decoder's `rx` input expects, plus a carrier-modulated `tx_mod` for the IR LED driver. It sits upstream of the decoder, so a `tx`→`rx` loopback closes the transreceiver path.

## Interface
- `CODEBITS`, 32, number of data bits per frame.
- `CLK_PER_TICK`, 1000, `clk` cycles per 10 µs timing tick (1000 = 100 MHz).
- `CARRIER_HALF`, 1316, `clk` cycles per carrier half-period (≈38 kHz at 100 MHz).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `code`  in  CODEBITS  command to send; sampled only when a `send` is accepted.
- `send`  in  1  request a full frame; accepted when `busy`=0.
- `send_repeat`  in  1  request a repeat frame; accepted when `busy`=0.
- `busy`  out  1  frame in progress; requests are ignored while it is high.
- `done`  out  1  one-cycle pulse at the end of the trailing gap.
- `tx`  out  1  frame level: idle 1, mark 0, space 1.
- `tx_mod`  out  1  carrier during marks, 0 otherwise.

## Operation
- All timing is in ticks (10 µs). The tick prescaler restarts at every state entry, so every phase lasts exactly N·`CLK_PER_TICK` cycles.
- Phase lengths in ticks:
  - LEAD_MARK 900
  - LEAD_SPACE 450 (full frame) / 225 (repeat)
  - BIT_MARK 56
  - BIT_SPACE 56 for '0', 169 for '1'
  - STOP_MARK 56
  - GAP 300
- These lengths satisfy the decoder's thresholds: space <100 ticks = 0, 100–199 = 1, ≥200 = end of frame.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- IDLE:
  - `send`=1 → latch `code` into the shift register, set the repeat flag to 0, go to LEAD_MARK.
  - Otherwise `send_repeat`=1 → set the repeat flag to 1, go to LEAD_MARK.
  - `send` has priority when both requests are high in the same cycle.
- LEAD_MARK → LEAD_SPACE.
- LEAD_SPACE:
  - Repeat flag = 1 → STOP_MARK (no data bits).
  - Repeat flag = 0 → BIT_MARK with the bit counter = 0.
- BIT_MARK → BIT_SPACE. The space length is taken from the current shift-register MSB.
- BIT_SPACE:
  - Shift the register left by 1 and increment the bit counter.
  - Bit counter reaches `CODEBITS` → STOP_MARK; otherwise → BIT_MARK.
- STOP_MARK → GAP → IDLE. `done` pulses in the final GAP cycle.
- Bits are transmitted MSB first, so the decoder's left-shifting buffer reproduces `code` exactly.
- `tx` = 0 in the *_MARK states and 1 in every other state.
- Carrier behaviour:
  - The carrier counter restarts at each mark entry with `tx_mod`=1.
  - `tx_mod` toggles every `CARRIER_HALF` cycles during a mark.
  - `tx_mod` is forced to 0 outside marks.
- `code` changes while `busy`=1 have no effect.
- Bit counter width: clog2(`CODEBITS`+1). Timer width must hold 900·`CLK_PER_TICK` or use a separate tick counter; no wrap is allowed within a phase.

## Timing
- Reset values: state IDLE, `tx`=1, `tx_mod`=0, `busy`=0, `done`=0; counters and shift register 0.
- All outputs are registered.
- Request sampled high at edge k with `busy`=0 → at k+1: `busy`=1, `tx`=0, `tx_mod`=1.
- The last GAP cycle has `done`=1 and `busy`=1. The following cycle has `busy`=0, and a new request is accepted at that edge.
- Full frame length = (1350 + 56·`CODEBITS` + Σspaces + 356) · `CLK_PER_TICK` cycles.
- Repeat frame length = (900 + 225 + 56 + 300) · `CLK_PER_TICK` cycles.
- `rst` asserted in any state, including mid-mark → next edge: all reset values, and no `done` pulse.
- A request that arrives while `busy`=1 is dropped, not queued.

## Test plan
Use `CLK_PER_TICK`=2 and `CARRIER_HALF`=3 unless stated otherwise.
- Reset test: hold `rst` for 3 cycles mid-frame → `tx`=1, `tx_mod`=0, `busy`=0, `done`=0 on the next cycle; a later `send` produces a clean frame.
- Full frame, `code`=32'h00FF_A55A:
  - `tx` low 1800 cycles, then high 900.
  - Then 32 bit slots: low 112 cycles, high 112 ('0') or 338 ('1'), MSB first.
  - Then low 112, high 600; `done` in the last cycle.
  - Total cycle count matches the formula.
- Repeat frame: `send_repeat` → `tx` low 1800, high 450, low 112, high 600, `done`; no data slots; total 2962 cycles.
- Arbitration:
  - `send` and `send_repeat` high in the same cycle → full frame.
  - `send` pulsed mid-frame with a different `code` → ignored; the transmitted bits equal the first `code`.
- Carrier: during LEAD_MARK `tx_mod` reads 1,1,1,0,0,0 repeating, starting at mark entry; `tx_mod`=0 throughout every space and in IDLE.
- Loopback with default parameters, `tx` wired to the decoder `rx`:
  - `code`=32'h20DF_10EF → decoder `code`=32'h20DF_10EF, `repeat_press`=0.
  - Then `send_repeat` → `repeat_press`=1, `code` unchanged.
